// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher (FIPS-197 InvCipher).
// The cipher key is expanded on-chip, one round key per cycle, into an
// (Nr+1)-entry bank. One inverse round per cycle then runs over a single
// state register. Handshake: start/busy/done. Latency is 2*Nr+1 edges.
module aes_decrypt_iter #(
    parameter int Nk = 4,   // key words; only 4 supported
    parameter int Nr = 10,  // rounds; only 10 supported
    parameter int Nb = 4    // state columns; fixed at 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [32*Nk-1:0]  key,
    input  logic [32*Nb-1:0]  in,
    output logic [32*Nb-1:0]  out,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_EXPAND = 3'd1;
    localparam logic [2:0] S_INIT   = 3'd2;
    localparam logic [2:0] S_ROUND  = 3'd3;
    localparam logic [2:0] S_FINAL  = 3'd4;

    localparam logic [3:0] LAST_RK = 4'(Nr);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] ISBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One KeyExpansion step: produce the next 4-word round key from the previous one.
    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] rot;
        logic [31:0] t;
        logic [31:0] w0, w1, w2, w3;
        rot = {k[23:0], k[31:24]};
        t   = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
              ^ {rc, 24'h000000};
        w0  = k[127:96] ^ t;
        w1  = k[95:64]  ^ w0;
        w2  = k[63:32]  ^ w1;
        w3  = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // InvShiftRows followed by InvSubBytes; byte (r,c) lives at bits [127-8*(r+4c) -: 8].
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = ISBOX[s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int unsigned i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
    endfunction

    logic [2:0]   fsm_q,   fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q [0:Nr];
    logic [127:0] rk_d [0:Nr];
    logic [7:0]   rcon_q,  rcon_d;
    logic [3:0]   cnt_q,   cnt_d;
    logic [127:0] out_q,   out_d;
    logic         busy_q,  busy_d;
    logic         done_q,  done_d;

    // Next-state logic: key expansion, whitening, inverse rounds, final output.
    // cnt_q doubles as the expansion index and the inverse-round index; the
    // state register holds the ciphertext between start and INIT.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rk_d    = rk_q;
        rcon_d  = rcon_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    rk_d[0] = key;
                    state_d = in;
                    rcon_d  = 8'h01;
                    cnt_d   = 4'd1;
                    busy_d  = 1'b1;
                    fsm_d   = S_EXPAND;
                end
            end
            S_EXPAND: begin
                rk_d[cnt_q] = key_step(rk_q[cnt_q - 4'd1], rcon_q);
                rcon_d      = xtime(rcon_q);
                cnt_d       = cnt_q + 4'd1;
                if (cnt_q == LAST_RK) begin
                    fsm_d = S_INIT;
                end
            end
            S_INIT: begin
                state_d = state_q ^ rk_q[Nr];
                cnt_d   = LAST_RK - 4'd1;
                fsm_d   = S_ROUND;
            end
            S_ROUND: begin
                state_d = inv_mix(inv_shift_sub(state_q) ^ rk_q[cnt_q]);
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    fsm_d = S_FINAL;
                end
            end
            S_FINAL: begin
                out_d  = inv_shift_sub(state_q) ^ rk_q[0];
                done_d = 1'b1;
                busy_d = 1'b0;
                fsm_d  = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            for (int unsigned i = 0; i <= Nr; i++) begin
                rk_q[i] <= '0;
            end
            rcon_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            rcon_q  <= rcon_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: directed FIPS-197 vectors, scoreboard queue
// filled at issue time and drained by an independent done monitor.
module tb_aes_decrypt_iter;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key   = '0;
    logic [127:0] ct    = '0;
    logic [127:0] pt;
    logic         busy;
    logic         done;

    aes_decrypt_iter #(.Nk(4), .Nr(10), .Nb(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .key   (key),
        .in    (ct),
        .out   (pt),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] data;
        int           edge_n;
    } exp_t;
    exp_t sb[$];

    int           n_cmp     = 0;
    int           n_bad     = 0;
    logic [127:0] hold_exp  = '0;
    logic         prev_done = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge while the DUT is IDLE; the next posedge accepts it,
    // and done appears after the 22nd posedge from now.
    task automatic issue(input logic [127:0] k, input logic [127:0] c, input logic [127:0] e);
        exp_t x;
        start  = 1'b1;
        key    = k;
        ct     = c;
        x.data   = e;
        x.edge_n = cyc + 22;
        sb.push_back(x);
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < limit);
        if (done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_done: no done within %0d cycles", limit);
        end
    endtask

    // Monitor: drain the scoreboard on done, check out holds between completions.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (done === 1'b1) begin
                    check("done_width", {127'b0, prev_done}, 128'd0);
                    check("busy_in_done", {127'b0, busy}, 128'd0);
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious_done: got done=1 expected no completion (t=%0t)", $time);
                    end else begin
                        e = sb.pop_front();
                        check("plaintext", pt, e.data);
                        check("done_edge", 128'(cyc), 128'(e.edge_n));
                        hold_exp = e.data;
                    end
                end else begin
                    check("out_hold", pt, hold_exp);
                end
                prev_done = done;
            end else begin
                prev_done = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Asynchronous reset: outputs clear before any clock edge.
        #2 rst = 1'b0;
        #1;
        check("rst_out", pt, 128'd0);
        check("rst_busy", {127'b0, busy}, 128'd0);
        check("rst_done", {127'b0, done}, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", {127'b0, busy}, 128'd0);

        // C.1 with an extra start pulse at E0+5 that must be ignored.
        issue(C1_KEY, C1_CT, C1_PT);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {127'b0, busy}, 128'd1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        key   = B_KEY;
        ct    = B_CT;
        @(negedge clk);
        start = 1'b0;
        key   = '0;
        ct    = '0;
        check("busy_mid_op", {127'b0, busy}, 128'd1);
        wait_done(30);

        // Back-to-back: App. B issued in the C.1 done cycle.
        issue(B_KEY, B_CT, B_PT);
        @(negedge clk);
        start = 1'b0;
        check("done_low_after_pulse", {127'b0, done}, 128'd0);
        check("busy_b2b", {127'b0, busy}, 128'd1);
        wait_done(30);
        check("rk10_probe", dut.rk_q[10], B_RK10);

        // Reset mid-operation at E0+12, then restart with C.1.
        @(negedge clk);
        issue(B_KEY, B_CT, B_PT);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_out", pt, 128'd0);
        check("midrst_busy", {127'b0, busy}, 128'd0);
        check("midrst_done", {127'b0, done}, 128'd0);
        sb.delete();
        hold_exp = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        issue(C1_KEY, C1_CT, C1_PT);
        @(negedge clk);
        start = 1'b0;
        wait_done(30);
        repeat (2) @(negedge clk);

        check("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
